pixel_dispatch: RTL and testbench
=================================

// Module: pixel_dispatch
// PURPOSE
//   Issues linear pixel addresses 0..H_DISP*V_DISP-1 to LANES parallel render lanes, round-robin.
//   Caps pixels in flight at WINDOW so the downstream reorder buffer (depth WINDOW) never
//   sees an address outside its window. Feeds the align/reorder stage.
//   Counts retirements from the reorder output to know when a frame has fully drained.
// PARAMETERS
//   H_DISP  1280  active pixels per line
//   V_DISP  720   active lines per frame
//   LANES   4     render lanes, >=1
//   WINDOW  16    max pixels in flight; power of 2; equals the reorder buffer depth N
//   ADDR_W  20    pixel address width; must satisfy 2**ADDR_W >= H_DISP*V_DISP
// PORTS
//   clk          in   1                    system clock
//   rst          in   1                    synchronous, active-high reset
//   frame_start  in   1                    pulse: start dispatching one frame
//   lane_ready   in   LANES                lane i can accept an address this cycle
//   lane_req     out  LANES                one-hot issue strobe, registered
//   lane_addr    out  ADDR_W               pixel address, qualified by |lane_req
//   retire       in   1                    one pixel left the reorder stage (sorted valid)
//   inflight     out  $clog2(WINDOW)+1     issued minus retired, 0..WINDOW
//   busy         out  1                    high in every state except IDLE
//   frame_done   out  1                    1-cycle pulse when the last pixel retires
//   err          out  1                    sticky: retire arrived while inflight==0
// BEHAVIOUR
//   Reset
//     - All outputs 0. State IDLE. Address counter 0. Round-robin pointer 0.
//   FSM: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
//     - IDLE: frame_start moves to RUN and clears the address counter.
//       frame_start outside IDLE is ignored.
//     - RUN: issue allowed when inflight < WINDOW and (lane_ready & ~0) != 0.
//       - Grant the first ready lane at or after rr_ptr, wrapping mod LANES. Then rr_ptr = grant+1 mod LANES.
//       - On the clock edge: lane_req = one-hot grant, lane_addr = addr, addr++, inflight++.
//       - lane_req is high for exactly one cycle per issue. No issue means lane_req = 0 and lane_addr holds its value.
//       - The stall check uses the registered inflight. A same-cycle retire does not unblock an issue.
//       - After issuing addr H_DISP*V_DISP-1, go to DRAIN.
//     - DRAIN: no issues. When inflight==0, go to DONE.
//     - DONE: frame_done=1 for one cycle, then IDLE.
//   inflight arithmetic
//     - Issue and retire in the same cycle: unchanged.
//     - Retire alone: -1. Retire with inflight==0: ignored, err<=1 (cleared only by rst).
//     - Never exceeds WINDOW.
//   Latency
//     - frame_start at cycle t gives the first lane_req at t+2 if a lane is ready.
//     - Last retire at t gives frame_done at t+2.
//   Reset mid-frame: next cycle is the reset state. Any pixels still in flight are forgotten.
// CONFIGURATION
//   DISPATCH_LINE_BARRIER_EN
//     - Defined: adds state LINE_WAIT. After issuing the last pixel of any line except the final one,
//       RUN goes to LINE_WAIT. It returns to RUN when inflight==0.
//       No pixel of line v+1 is issued before all of line v has retired.
//     - Undefined: no LINE_WAIT. Lines are dispatched back to back.
// TESTING  (H_DISP=4, V_DISP=2, LANES=2, WINDOW=4 unless noted)
//   1 Reset: rst for 2 cycles -> all outputs 0, busy=0.
//     frame_start while rst=1 -> busy stays 0.
//   2 Window stall: lane_ready=11, retire=0, frame_start
//     -> addresses 0,1,2,3 on lanes 0,1,0,1 in consecutive cycles, then inflight=4 and lane_req=0.
//     One retire pulse -> addr 4 issued on lane 0 two cycles later.
//   3 Round-robin skip: LANES=4, WINDOW=16, lane_ready=0101
//     -> grants lane0, lane2, lane0, lane2 with addresses 0,1,2,3.
//   4 Full frame: retire pulsed one cycle after each lane_req
//     -> exactly 8 issues (addr 0..7), then DRAIN, then one frame_done pulse.
//     inflight=0, busy=0 afterwards.
//   5 Counters: retire with inflight=0 -> err=1 and stays 1, inflight stays 0.
//     Issue and retire together at inflight=2 -> inflight stays 2.
//   6 Reset/ignore: frame_start in RUN -> addresses continue unchanged.
//     rst at addr 3 -> lane_req=0, inflight=0, busy=0 next cycle.
//     New frame restarts at addr 0 with lane 0.
//   7 With DISPATCH_LINE_BARRIER_EN, retire=0
//     -> issues stop after addr 3. Addr 4 is issued only after 4 retires.

Source files
------------

// File: rtl/pixel_dispatch.sv
// pixel_dispatch: issues linear pixel addresses 0..H_DISP*V_DISP-1 round-robin
// to LANES render lanes, holding at most WINDOW pixels in flight so the
// downstream reorder buffer never sees an address outside its window.
// Retirements from the reorder output are counted to detect frame drain.
// Optional feature macro: DISPATCH_LINE_BARRIER_EN adds a LINE_WAIT state that
// holds dispatch at each line boundary until every pixel of the line retired.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for frame_start
// RUN       | issuing addresses while the window and a ready lane allow
// LINE_WAIT | (barrier build only) line finished, waiting for inflight==0
// DRAIN     | all addresses issued, waiting for inflight==0
// DONE      | frame_done pulse, back to IDLE next cycle
module pixel_dispatch #(
    parameter int H_DISP = 1280,
    parameter int V_DISP = 720,
    parameter int LANES  = 4,
    parameter int WINDOW = 16,
    parameter int ADDR_W = 20
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_start,
    input  logic [LANES-1:0]          lane_ready,
    output logic [LANES-1:0]          lane_req,
    output logic [ADDR_W-1:0]         lane_addr,
    input  logic                      retire,
    output logic [$clog2(WINDOW):0]   inflight,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      err
);

    localparam int IW = $clog2(WINDOW) + 1;
    localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_DISP * V_DISP - 1);
    localparam logic [IW-1:0]     WIN       = IW'(WINDOW);
    localparam logic [PW-1:0]     LAST_LANE = PW'(LANES - 1);

`ifdef DISPATCH_LINE_BARRIER_EN
    localparam int CW = (H_DISP > 1) ? $clog2(H_DISP) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(H_DISP - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUN       = 3'd1,
        DRAIN     = 3'd2,
        DONE      = 3'd3,
        LINE_WAIT = 3'd4
    } state_t;

    logic [CW-1:0] col;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;
`endif

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     scan_idx;
    logic [PW-1:0]     grant_idx;
    logic              grant_found;
    logic              issue;
    logic              retire_ok;
    logic [IW-1:0]     inflight_nxt;

    // first ready lane at or after rr_ptr, wrapping around the lane count
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = rr_ptr;
        for (int k = 0; k < LANES; k++) begin
            if (!grant_found && lane_ready[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
            scan_idx = (scan_idx == LAST_LANE) ? '0 : scan_idx + PW'(1);
        end
    end

    // issue gate uses the registered inflight; a stray retire at zero is dropped
    always_comb begin
        issue        = (state == RUN) && (inflight < WIN) && grant_found;
        retire_ok    = retire && (inflight != '0);
        inflight_nxt = inflight + IW'(issue) - IW'(retire_ok);
    end

    // sequencing FSM with registered outputs and in-flight accounting
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr       <= '0;
            rr_ptr     <= '0;
            lane_req   <= '0;
            lane_addr  <= '0;
            inflight   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
`ifdef DISPATCH_LINE_BARRIER_EN
            col        <= '0;
`endif
        end else begin
            lane_req   <= '0;
            frame_done <= 1'b0;
            inflight   <= inflight_nxt;
            if (retire && (inflight == '0)) begin
                err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state <= RUN;
                        addr  <= '0;
                        busy  <= 1'b1;
`ifdef DISPATCH_LINE_BARRIER_EN
                        col   <= '0;
`endif
                    end
                end
                RUN: begin
                    if (issue) begin
                        lane_req  <= LANES'(1) << grant_idx;
                        lane_addr <= addr;
                        addr      <= addr + ADDR_W'(1);
                        rr_ptr    <= (grant_idx == LAST_LANE) ? '0 : grant_idx + PW'(1);
`ifdef DISPATCH_LINE_BARRIER_EN
                        col       <= (col == LAST_COL) ? '0 : col + CW'(1);
                        if (addr == LAST_ADDR) begin
                            state <= DRAIN;
                        end else if (col == LAST_COL) begin
                            state <= LINE_WAIT;
                        end
`else
                        if (addr == LAST_ADDR) begin
                            state <= DRAIN;
                        end
`endif
                    end
                end
`ifdef DISPATCH_LINE_BARRIER_EN
                LINE_WAIT: begin
                    if (inflight == '0) begin
                        state <= RUN;
                    end
                end
`endif
                DRAIN: begin
                    if (inflight == '0) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_dispatch.sv
// tb_pixel_dispatch: table-driven vectors, hand-written corner sequences and
// randomized traffic checked against a count-based reference model.
module tb_pixel_dispatch;

    localparam int H     = 4;
    localparam int V     = 2;
    localparam int L     = 2;
    localparam int W     = 4;
    localparam int TOTAL = H * V;
`ifdef DISPATCH_LINE_BARRIER_EN
    localparam bit BARRIER = 1'b1;
`else
    localparam bit BARRIER = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_WAIT  = 2;
    localparam int M_DRAIN = 3;
    localparam int M_DONE  = 4;

    logic       clk;
    logic       rst;
    logic       fs;
    logic [1:0] rdy;
    logic       ret;
    logic [1:0] lane_req;
    logic [3:0] lane_addr;
    logic [2:0] inflight;
    logic       busy;
    logic       frame_done;
    logic       err;

    logic       fs1;
    logic [3:0] rdy1;
    logic       ret1;
    logic [3:0] lane_req1;
    logic [3:0] lane_addr1;
    logic [4:0] inflight1;
    logic       busy1;
    logic       frame_done1;
    logic       err1;

    int n_cmp;
    int n_fail;

    int m_mode, m_next, m_infl, m_rr, m_req, m_addr;
    bit m_err, m_busy, m_done;

    typedef struct {
        bit fs;
        int rdy;
        bit ret;
        int req;
        int addr;
        int infl;
        bit busy;
        bit done;
    } vec_t;

    vec_t tbl[$];

    pixel_dispatch #(.H_DISP(H), .V_DISP(V), .LANES(L), .WINDOW(W), .ADDR_W(4)) u0 (
        .clk(clk), .rst(rst), .frame_start(fs), .lane_ready(rdy),
        .lane_req(lane_req), .lane_addr(lane_addr), .retire(ret),
        .inflight(inflight), .busy(busy), .frame_done(frame_done), .err(err)
    );

    pixel_dispatch #(.H_DISP(H), .V_DISP(V), .LANES(4), .WINDOW(16), .ADDR_W(4)) u1 (
        .clk(clk), .rst(rst), .frame_start(fs1), .lane_ready(rdy1),
        .lane_req(lane_req1), .lane_addr(lane_addr1), .retire(ret1),
        .inflight(inflight1), .busy(busy1), .frame_done(frame_done1), .err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // reference: pixels issued/retired as counts, grant found by modular scan
    task automatic model_edge();
        int  g;
        int  idx;
        bit  ret_ok;
        int  nxt;
        if (rst) begin
            m_mode = M_IDLE; m_next = 0; m_infl = 0; m_rr = 0; m_err = 1'b0;
            m_req = 0; m_addr = 0; m_busy = 1'b0; m_done = 1'b0;
        end else begin
            g = -1;
            if (m_mode == M_RUN && m_infl < W) begin
                for (int k = 0; k < L; k++) begin
                    idx = (m_rr + k) % L;
                    if (g < 0 && ((int'(rdy) >> idx) & 1) != 0) g = idx;
                end
            end
            ret_ok = ret && (m_infl > 0);
            if (ret && m_infl == 0) m_err = 1'b1;
            nxt = m_infl + ((g >= 0) ? 1 : 0) - (ret_ok ? 1 : 0);
            m_req  = 0;
            m_done = 1'b0;
            case (m_mode)
                M_IDLE:  if (fs) begin m_mode = M_RUN; m_next = 0; end
                M_RUN: begin
                    if (g >= 0) begin
                        m_req  = 1 << g;
                        m_addr = m_next;
                        m_rr   = (g + 1) % L;
                        m_next = m_next + 1;
                        if (m_next == TOTAL) m_mode = M_DRAIN;
                        else if (BARRIER && (m_next % H) == 0) m_mode = M_WAIT;
                    end
                end
                M_WAIT:  if (m_infl == 0) m_mode = M_RUN;
                M_DRAIN: if (m_infl == 0) begin m_mode = M_DONE; m_done = 1'b1; end
                default: m_mode = M_IDLE;
            endcase
            m_infl = nxt;
            m_busy = (m_mode != M_IDLE);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model_lane_req", int'(lane_req), m_req);
        check("model_lane_addr", int'(lane_addr), m_addr);
        check("model_inflight", int'(inflight), m_infl);
        check("model_busy", int'(busy), int'(m_busy));
        check("model_frame_done", int'(frame_done), int'(m_done));
        check("model_err", int'(err), int'(m_err));
    endtask

    task automatic add_row(input bit f, input int r, input bit rt, input int rq,
                           input int a, input int inf, input bit b, input bit d);
        vec_t v;
        v.fs = f; v.rdy = r; v.ret = rt; v.req = rq; v.addr = a;
        v.infl = inf; v.busy = b; v.done = d;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        rst = 1'b1; fs = 1'b0; ret = 1'b0; rdy = 2'b00;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int issues;
        int dones;
        n_cmp = 0; n_fail = 0;
        rst = 1'b1; fs = 1'b0; rdy = 2'b00; ret = 1'b0;
        fs1 = 1'b0; rdy1 = 4'b0000; ret1 = 1'b0;

        // reset, with frame_start held during reset
        fs = 1'b1;
        step();
        step();
        check("rst_lane_req", int'(lane_req), 0);
        check("rst_lane_addr", int'(lane_addr), 0);
        check("rst_inflight", int'(inflight), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_err", int'(err), 0);
        rst = 1'b0; fs = 1'b0;
        step();
        check("rst_fs_ignored_busy", int'(busy), 0);

        // round-robin skip on the 4-lane instance
        fs1 = 1'b1; rdy1 = 4'b0101;
        step();
        fs1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr_skip_req", int'(lane_req1), (i % 2 == 0) ? 1 : 4);
            check("rr_skip_addr", int'(lane_addr1), i);
        end
        check("rr_skip_inflight", int'(inflight1), 4);
        check("rr_skip_busy", int'(busy1), 1);
        check("rr_skip_err", int'(err1) + int'(frame_done1), 0);
        rdy1 = 4'b0000;

        // window stall vectors
        add_row(1, 3, 0, 0, 0, 0, 1, 0);
        add_row(0, 3, 0, 1, 0, 1, 1, 0);
        add_row(0, 3, 0, 2, 1, 2, 1, 0);
        add_row(0, 3, 0, 1, 2, 3, 1, 0);
        add_row(0, 3, 0, 2, 3, 4, 1, 0);
        add_row(0, 3, 0, 0, 3, 4, 1, 0);
        if (BARRIER) begin
            add_row(0, 3, 1, 0, 3, 3, 1, 0);
            add_row(0, 3, 1, 0, 3, 2, 1, 0);
            add_row(0, 3, 1, 0, 3, 1, 1, 0);
            add_row(0, 3, 1, 0, 3, 0, 1, 0);
            add_row(0, 3, 0, 0, 3, 0, 1, 0);
            add_row(0, 3, 0, 1, 4, 1, 1, 0);
        end else begin
            add_row(0, 3, 1, 0, 3, 3, 1, 0);
            add_row(0, 3, 0, 1, 4, 4, 1, 0);
            add_row(0, 3, 1, 0, 4, 3, 1, 0);
            add_row(0, 3, 1, 2, 5, 3, 1, 0);
            add_row(0, 3, 1, 1, 6, 3, 1, 0);
            add_row(0, 3, 1, 2, 7, 3, 1, 0);
            add_row(0, 3, 1, 0, 7, 2, 1, 0);
            add_row(0, 3, 1, 0, 7, 1, 1, 0);
            add_row(0, 3, 1, 0, 7, 0, 1, 0);
            add_row(0, 3, 0, 0, 7, 0, 1, 1);
            add_row(0, 3, 0, 0, 7, 0, 0, 0);
        end
        foreach (tbl[i]) begin
            fs = tbl[i].fs; rdy = 2'(tbl[i].rdy); ret = tbl[i].ret;
            step();
            check("vec_lane_req", int'(lane_req), tbl[i].req);
            check("vec_lane_addr", int'(lane_addr), tbl[i].addr);
            check("vec_inflight", int'(inflight), tbl[i].infl);
            check("vec_busy", int'(busy), int'(tbl[i].busy));
            check("vec_frame_done", int'(frame_done), int'(tbl[i].done));
        end
        do_reset();

        // full frame, retire one cycle after each issue
        rdy = 2'b11; fs = 1'b1; ret = 1'b0;
        step();
        fs = 1'b0;
        issues = 0; dones = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (lane_req != 2'b00) begin
                check("frame_addr_seq", int'(lane_addr), issues);
                issues++;
            end
            if (frame_done) dones++;
            ret = (lane_req != 2'b00);
            if (!busy) break;
        end
        ret = 1'b0;
        check("frame_issue_count", issues, TOTAL);
        check("frame_done_count", dones, 1);
        check("frame_end_inflight", int'(inflight), 0);
        check("frame_end_busy", int'(busy), 0);

        // err is sticky; issue plus retire leaves inflight unchanged
        rdy = 2'b00; ret = 1'b1;
        step();
        check("err_set", int'(err), 1);
        check("err_inflight_zero", int'(inflight), 0);
        ret = 1'b0;
        step();
        check("err_sticky", int'(err), 1);
        rdy = 2'b11; fs = 1'b1;
        step();
        fs = 1'b0;
        step();
        step();
        check("pre_balance_inflight", int'(inflight), 2);
        ret = 1'b1;
        step();
        check("balance_issue", int'(lane_req), 1);
        check("balance_inflight", int'(inflight), 2);
        ret = 1'b0;
        do_reset();
        check("err_cleared_by_rst", int'(err), 0);

        // frame_start in RUN ignored, then reset mid-frame
        rdy = 2'b11; fs = 1'b1;
        step();
        fs = 1'b0;
        step();
        fs = 1'b1;
        step();
        check("ignore_fs_addr1", int'(lane_addr), 1);
        fs = 1'b0;
        step();
        step();
        check("mid_addr3", int'(lane_addr), 3);
        rst = 1'b1;
        step();
        check("mid_rst_req", int'(lane_req), 0);
        check("mid_rst_inflight", int'(inflight), 0);
        check("mid_rst_busy", int'(busy), 0);
        rst = 1'b0; fs = 1'b1;
        step();
        fs = 1'b0;
        step();
        check("restart_req", int'(lane_req), 1);
        check("restart_addr", int'(lane_addr), 0);
        do_reset();

        // randomized traffic against the reference model
        for (int i = 0; i < 2000; i++) begin
            rdy = 2'($urandom_range(0, 3));
            ret = (m_infl > 0) && ($urandom_range(0, 2) != 0);
            fs  = ($urandom_range(0, 5) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
